// File: rtl/conv8_feeder.sv
// Column sequencer for the Conv8 core: holds a 3x3 filter bank and streams input
// columns, the filter columns (first three beats only), a flush beat and drain beats.

package definition;
    localparam int width = 8;
endpackage

module conv8_feeder #(
    parameter int WIDTH = definition::width,
    parameter int COLS  = 8,
    parameter int DRAIN = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               w_we,
    input  logic [3:0]         w_addr,
    input  logic [WIDTH-1:0]   w_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*WIDTH-1:0] s_data,
    output logic               o_en,
    output logic [WIDTH-1:0]   o_r1,
    output logic [WIDTH-1:0]   o_r2,
    output logic [WIDTH-1:0]   o_r3,
    output logic [WIDTH-1:0]   o_r4,
    output logic [WIDTH-1:0]   o_r5,
    output logic [WIDTH-1:0]   o_r6,
    output logic [WIDTH-1:0]   o_r7,
    output logic [WIDTH-1:0]   o_r8,
    output logic [WIDTH-1:0]   o_f1,
    output logic [WIDTH-1:0]   o_f2,
    output logic [WIDTH-1:0]   o_f3
);

    localparam int CW  = $clog2(COLS);
    localparam int DCW = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

    localparam logic [CW-1:0]  LAST_COL  = CW'(COLS - 1);
    localparam logic [CW-1:0]  FILT_COLS = CW'(3);
    localparam logic [DCW-1:0] DRAIN_END = DCW'(DRAIN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    state_t                  state_reg,  state_next;
    logic [CW-1:0]           col_reg,    col_next;
    logic [DCW-1:0]          dcnt_reg,   dcnt_next;
    logic                    en_reg,     en_next;
    logic                    done_reg,   done_next;
    logic [7:0][WIDTH-1:0]   row_reg,    row_next;
    logic [2:0][WIDTH-1:0]   filt_reg,   filt_next;

    logic [8:0][WIDTH-1:0]   weight_reg;
    logic [8:0]              w_sel;
    logic [2:0][WIDTH-1:0]   beat_filt;
    logic                    idle;
    logic                    beat;

    assign idle    = (state_reg == ST_IDLE);
    assign busy    = !idle;
    assign s_ready = (state_reg == ST_FEED);
    assign beat    = s_valid && s_ready;
    assign done    = done_reg;
    assign o_en    = en_reg;

    // Weight bank only accepts writes between tiles; addresses 9..15 decode to nothing.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_wsel
            assign w_sel[gi] = w_we && idle && (w_addr == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weight_reg <= '0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (w_sel[k]) begin
                    weight_reg[k] <= w_data;
                end
            end
        end
    end

    // Filter column c of the row-major bank is (w[c], w[3+c], w[6+c]).
    always_comb begin
        beat_filt = '0;
        if (col_reg < FILT_COLS) begin
            case (col_reg[1:0])
                2'd0: begin
                    beat_filt[0] = weight_reg[0];
                    beat_filt[1] = weight_reg[3];
                    beat_filt[2] = weight_reg[6];
                end
                2'd1: begin
                    beat_filt[0] = weight_reg[1];
                    beat_filt[1] = weight_reg[4];
                    beat_filt[2] = weight_reg[7];
                end
                2'd2: begin
                    beat_filt[0] = weight_reg[2];
                    beat_filt[1] = weight_reg[5];
                    beat_filt[2] = weight_reg[8];
                end
                default: beat_filt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            col_reg   <= '0;
            dcnt_reg  <= '0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b0;
            row_reg   <= '0;
            filt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            dcnt_reg  <= dcnt_next;
            en_reg    <= en_next;
            done_reg  <= done_next;
            row_reg   <= row_next;
            filt_reg  <= filt_next;
        end
    end

    // Outputs are registered, so each state programs what the core sees next cycle.
    // DRAIN lasts DRAIN+1 cycles: DRAIN enabled zero beats, then the done edge.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        dcnt_next  = dcnt_reg;
        en_next    = 1'b0;
        done_next  = 1'b0;
        row_next   = row_reg;
        filt_next  = filt_reg;
        case (state_reg)
            ST_IDLE: begin
                row_next  = '0;
                filt_next = '0;
                if (start) begin
                    state_next = ST_FEED;
                    col_next   = '0;
                    dcnt_next  = '0;
                end
            end
            ST_FEED: begin
                // A stall keeps data registers frozen and drops the enable.
                if (beat) begin
                    row_next  = s_data;
                    filt_next = beat_filt;
                    en_next   = 1'b1;
                    col_next  = col_reg + 1'b1;
                    if (col_reg == LAST_COL) begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                row_next   = '0;
                filt_next  = '0;
                en_next    = 1'b1;
                dcnt_next  = '0;
                state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                row_next  = '0;
                filt_next = '0;
                if (dcnt_reg == DRAIN_END) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    en_next   = 1'b1;
                    dcnt_next = dcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_r1 = row_reg[0];
    assign o_r2 = row_reg[1];
    assign o_r3 = row_reg[2];
    assign o_r4 = row_reg[3];
    assign o_r5 = row_reg[4];
    assign o_r6 = row_reg[5];
    assign o_r7 = row_reg[6];
    assign o_r8 = row_reg[7];
    assign o_f1 = filt_reg[0];
    assign o_f2 = filt_reg[1];
    assign o_f3 = filt_reg[2];

endmodule

// File: tb/tb_conv8_feeder.sv
// Directed bench for conv8_feeder: nominal, stalled, write-protected, aborted
// and back-to-back tiles, each cycle checked against hand-derived values.

module tb_conv8_feeder;

    localparam int W = 8;

    int checks = 0;
    int errors = 0;

    logic         clk;
    logic         rstn;
    logic         start;
    logic         busy;
    logic         done;
    logic         w_we;
    logic [3:0]   w_addr;
    logic [W-1:0] w_data;
    logic         s_valid;
    logic         s_ready;
    logic [8*W-1:0] s_data;
    logic         o_en;
    logic [W-1:0] o_r1, o_r2, o_r3, o_r4, o_r5, o_r6, o_r7, o_r8;
    logic [W-1:0] o_f1, o_f2, o_f3;

    logic [63:0]  rows_bus;
    logic [23:0]  filt_bus;
    logic [7:0]   exp_w [9];

    assign rows_bus = {o_r8, o_r7, o_r6, o_r5, o_r4, o_r3, o_r2, o_r1};
    assign filt_bus = {o_f3, o_f2, o_f1};

    conv8_feeder #(.WIDTH(W), .COLS(8), .DRAIN(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .o_en    (o_en),
        .o_r1    (o_r1),
        .o_r2    (o_r2),
        .o_r3    (o_r3),
        .o_r4    (o_r4),
        .o_r5    (o_r5),
        .o_r6    (o_r6),
        .o_r7    (o_r7),
        .o_r8    (o_r8),
        .o_f1    (o_f1),
        .o_f2    (o_f2),
        .o_f3    (o_f3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Column j: lane k carries {j, k} so lane-to-row mapping is visible.
    function automatic logic [63:0] col_pat(input int j);
        logic [63:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p[k*8 +: 8] = {4'(j), 4'(k)};
        end
        return p;
    endfunction

    // Beat j (1-based) carries filter column j-1 as {f3,f2,f1} for j<=3, else zero.
    function automatic logic [23:0] filt_exp(input int j);
        if (j >= 1 && j <= 3) begin
            return {exp_w[j+5], exp_w[j+2], exp_w[j-1]};
        end
        return '0;
    endfunction

    task automatic write_w(input int addr, input int data);
        w_we   = 1'b1;
        w_addr = 4'(addr);
        w_data = 8'(data);
        tick();
        w_we   = 1'b0;
        $display("weight write addr %0d data %0h", addr, data);
    endtask

    task automatic check_zero_outs(input string tag);
        check_val({tag, "_en"},   64'(o_en),     64'd0);
        check_val({tag, "_rows"}, rows_bus,      64'd0);
        check_val({tag, "_filt"}, 64'(filt_bus), 64'd0);
        check_val({tag, "_busy"}, 64'(busy),     64'd0);
        check_val({tag, "_rdy"},  64'(s_ready),  64'd0);
        check_val({tag, "_done"}, 64'(done),     64'd0);
    endtask

    task automatic run_tile(input string name, input int stall_at, input int stall_n,
                            input bit poke, input bit b2b);
        int en_cnt;
        int cyc;
        en_cnt = 0;
        cyc    = 0;
        start  = 1'b1;
        tick();
        start  = poke;
        cyc++;
        en_cnt += int'(o_en);
        check_val("start_busy", 64'(busy),    64'd1);
        check_val("start_rdy",  64'(s_ready), 64'd1);
        check_val("start_en",   64'(o_en),    64'd0);
        for (int j = 1; j <= 8; j++) begin
            s_valid = 1'b1;
            s_data  = col_pat(j);
            if (poke) begin
                w_we   = 1'b1;
                w_addr = 4'd4;
                w_data = 8'hFF;
            end
            tick();
            cyc++;
            en_cnt += int'(o_en);
            check_val("beat_en",   64'(o_en),     64'd1);
            check_val("beat_rows", rows_bus,      col_pat(j));
            check_val("beat_filt", 64'(filt_bus), 64'(filt_exp(j)));
            if (j == stall_at) begin
                for (int n = 0; n < stall_n; n++) begin
                    s_valid = 1'b0;
                    s_data  = '1;
                    tick();
                    cyc++;
                    en_cnt += int'(o_en);
                    check_val("stall_en",   64'(o_en),     64'd0);
                    check_val("stall_rdy",  64'(s_ready),  64'd1);
                    check_val("stall_rows", rows_bus,      col_pat(j));
                    check_val("stall_filt", 64'(filt_bus), 64'(filt_exp(j)));
                end
            end
        end
        s_valid = 1'b0;
        s_data  = '0;
        w_we    = 1'b0;
        tick();
        cyc++;
        en_cnt += int'(o_en);
        check_val("flush_en",   64'(o_en),     64'd1);
        check_val("flush_rows", rows_bus,      64'd0);
        check_val("flush_filt", 64'(filt_bus), 64'd0);
        check_val("flush_rdy",  64'(s_ready),  64'd0);
        for (int d = 0; d < 4; d++) begin
            tick();
            cyc++;
            en_cnt += int'(o_en);
            check_val("drain_en",   64'(o_en),  64'd1);
            check_val("drain_rows", rows_bus,   64'd0);
            check_val("drain_busy", 64'(busy),  64'd1);
            check_val("drain_done", 64'(done),  64'd0);
        end
        tick();
        start = 1'b0;
        check_val("done_pulse", 64'(done),    64'd1);
        check_val("done_busy",  64'(busy),    64'd0);
        check_val("done_en",    64'(o_en),    64'd0);
        check_val("done_rows",  rows_bus,     64'd0);
        check_val("en_total",   64'(en_cnt),  64'd13);
        check_val("tile_cycles", 64'(cyc),    64'(14 + stall_n));
        $display("tile %s cycles %0d en_cycles %0d", name, cyc, en_cnt);
        if (b2b) begin
            start = 1'b1;
        end else begin
            tick();
            check_zero_outs({name, "_post"});
        end
    endtask

    task automatic abort_tile();
        bit seen_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            s_valid = 1'b1;
            s_data  = col_pat(j);
            tick();
            check_val("abort_beat_rows", rows_bus, col_pat(j));
        end
        s_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_zero_outs("abort_async");
        tick();
        rstn = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_done |= done;
        end
        check_val("abort_no_done", 64'(seen_done), 64'd0);
        check_val("abort_idle",    64'(busy),      64'd0);
        $display("tile abort reset after beat 5");
    endtask

    initial begin
        rstn    = 1'b1;
        start   = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_data  = '0;
        s_valid = 1'b0;
        s_data  = '0;

        #3 rstn = 1'b0;
        #1;
        check_zero_outs("reset_async");
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check_zero_outs("reset_release");

        for (int a = 0; a < 9; a++) begin
            write_w(a, a + 1);
            exp_w[a] = 8'(a + 1);
        end

        // Writes to addr 4 and start pulses while busy must not disturb anything.
        run_tile("poke", 0, 0, 1'b1, 1'b0);

        for (int a = 9; a < 16; a++) begin
            write_w(a, 8'hAA);
        end

        run_tile("nominal", 0, 0, 1'b0, 1'b0);
        run_tile("stall", 3, 2, 1'b0, 1'b0);
        run_tile("b2b_first", 0, 0, 1'b0, 1'b1);
        run_tile("b2b_second", 0, 0, 1'b0, 1'b0);

        abort_tile();
        for (int a = 0; a < 9; a++) begin
            exp_w[a] = 8'd0;
        end
        run_tile("cleared_w", 0, 0, 1'b0, 1'b0);

        for (int a = 0; a < 9; a++) begin
            write_w(a, a + 1);
            exp_w[a] = 8'(a + 1);
        end
        run_tile("reloaded", 0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv8_feeder.md
# conv8_feeder

Synthesizable column sequencer that drives the `Conv8_core` input interface. It stores a 3×3 filter and accepts an 8-pixel input column per handshake beat. For each tile it emits the row columns and filter columns to the core, with the filter applied column-by-column over the first three beats. It then flushes and drains the core and signals completion, replacing bench-driven stimulus with an in-design producer.

## Interface
- `WIDTH`, default `definition::width`: data width of pixels and weights.
- `COLS`, default 8: input columns per tile (≥3).
- `DRAIN`, default 4: zero-input cycles with `o_en` high after flush.

- `clk  in  1`: single clock, rising edge.
- `rstn  in  1`: reset, asynchronous, active-low.
- `start  in  1`: begin a tile; ignored unless idle.
- `busy  out  1`: high from the cycle after accepted start until done.
- `done  out  1`: one-cycle pulse at tile end.
- `w_we  in  1`: weight write strobe.
- `w_addr  in  4`: weight address; a = 3·row + col (row-major, 0..8).
- `w_data  in  WIDTH`: weight value.
- `s_valid  in  1`: input column valid.
- `s_ready  out  1`: input column ready.
- `s_data  in  8·WIDTH`: column; lane k (bits [k·WIDTH +: WIDTH]) maps to row k+1.
- `o_en  out  1`: core enable.
- `o_r1..o_r8  out  WIDTH each`: row pixels to core.
- `o_f1..o_f3  out  WIDTH each`: filter column to core.

## Operation
- Weight bank: 9 × WIDTH registers.
  - Written when `w_we` && !`busy` && `w_addr` ≤ 8.
  - Writes with `busy` high, or to addresses 9..15, are ignored.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - `o_en`=0; all `o_r*`/`o_f*`=0; `s_ready`=0.
  - `start`=1 → FEED; column counter c=0; drain counter cleared.
- FEED:
  - `s_ready`=1 (combinational from state).
  - On a beat (`s_valid`&&`s_ready`) at an edge, registered outputs become:
    - `o_r(k+1)` = lane k.
    - If c<3: `o_f1`=w[c], `o_f2`=w[3+c], `o_f3`=w[6+c]. Otherwise `o_f*`=0.
    - `o_en`=1; c increments.
  - On a non-beat edge (stall): `o_en`=0 and `o_r*`/`o_f*` hold their previous values. The core freezes.
  - After beat number COLS → FLUSH.
- FLUSH: one cycle with `o_r*`=0, `o_f*`=0, `o_en`=1; then → DRAIN.
- DRAIN:
  - DRAIN cycles with zero data and `o_en`=1.
  - Then → IDLE, `done`=1 for one cycle, `busy`=0, `o_en`=0, data outputs 0.
- `start` while busy is ignored. A `start` in the same cycle as `done` is accepted (state is IDLE at that edge only if already IDLE; a `start` during the last DRAIN cycle is ignored).
- Arithmetic: none; pure data routing. No width growth (`o_sum*` widths belong to the core).

## Timing
- Reset (async assert): state IDLE; `busy`, `done`, `o_en`, `s_ready` = 0; all `o_r*`, `o_f*` = 0; all weights = 0; counters 0. Deassertion is synchronous-safe; first active edge sees IDLE.
- Reset mid-tile aborts immediately. No `done` is produced for the aborted tile.
- `start` sampled at edge t → `busy`=1 and `s_ready`=1 during cycle t+1.
- Beat accepted at edge e → outputs valid from e until the next edge (1-cycle latency, registered).
- No-stall tile: `o_en` high for COLS+1+DRAIN consecutive cycles (13 at defaults). `done` is high in the cycle immediately after the last DRAIN cycle.
- Each stall cycle extends the tile by exactly one cycle with `o_en` low.

## Test plan
- Reset: hold `rstn`=0 mid-clock → all outputs 0 asynchronously; after release, `busy`=0 and `s_ready`=0.
- Nominal tile:
  - Stimulus: write weights 1..9 to addresses 0..8; `start`; stream 8 columns with all lanes = 1..8 and `s_valid` constantly high.
  - Filter: (1,4,7), (2,5,8), (3,6,9) on `o_f1..3` in en-cycles 1–3, then 0.
  - Rows: `o_r*` = 1..8, then 0 for 5 cycles.
  - `o_en` high 13 cycles; one `done` pulse.
- Stall: nominal tile with `s_valid`=0 for 2 cycles after beat 3 → `o_en` low for 2 cycles, `o_r*`=3 and `o_f*`=(3,6,9) held; beat 4 carries `o_f*`=0; `o_en` total still 13 and tile 2 cycles longer.
- Write protection:
  - Write 0xFF to addr 4 during FEED → ignored; second tile still shows `o_f2`=5 at c=1.
  - Write to addr 12 in IDLE → no weight changes.
  - `start` during busy → no effect.
- Reset mid-FEED (after beat 5) → outputs and weights 0 immediately; no `done`; a new tile after reloading weights behaves as nominal.
- Back-to-back: assert `start` in the `done` cycle → second tile starts; `busy` drops for exactly that one cycle.
